// File: rtl/loop_sequencer.sv
// loop_sequencer: accepts a (count, reps) command and launches the loop
// engine `reps` times with `count` iterations each. It waits for the
// engine's completion between runs and pulses `done` when the command ends.
// Optional watchdog: define LOOP_SEQ_TIMEOUT_EN to abort a run that stays
// in WAIT for TMO_CYC cycles.
module loop_sequencer #(
  parameter int CNT_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [3:0]       cmd_reps,
  output logic             eng_start,
  output logic [CNT_W-1:0] eng_count,
  input  logic             eng_finish,
  output logic             busy,
  output logic             done,
  output logic [3:0]       runs_done,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count_q;
  logic [3:0]       reps_q;
  logic [3:0]       runs_q;
  logic [3:0]       runs_inc;
  logic             accept;
  logic             finish_hit;
  logic             tmo_hit;

  // Run counter never wraps: it sticks at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign accept     = (state == S_IDLE) && cmd_valid;
  assign finish_hit = (state == S_WAIT) && eng_finish;
  assign runs_inc   = sat_inc4(runs_q);

  assign cmd_ready = (state == S_IDLE);
  assign eng_start = (state == S_LAUNCH);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign eng_count = count_q;
  assign runs_done = runs_q;

`ifdef LOOP_SEQ_TIMEOUT_EN
  localparam int TW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          timeout_q;

  // The last permitted WAIT cycle is the one where the counter reads TMO_CYC-1.
  assign tmo_hit = (state == S_WAIT) && !eng_finish && (tmo_cnt == TW'(TMO_CYC - 1));
  assign timeout = timeout_q;

  // Watchdog: counts WAIT cycles, restarts from 0 on every entry to WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      else                 tmo_cnt <= '0;
      if (accept)       timeout_q <= 1'b0;
      else if (tmo_hit) timeout_q <= 1'b1;
    end
  end
`else
  // No watchdog: WAIT holds until the engine finishes.
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; completions outside WAIT are stale and dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (cmd_valid) state_nxt = (cmd_reps != 4'd0) ? S_LAUNCH : S_DONE;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (finish_hit)   state_nxt = (runs_inc == reps_q) ? S_DONE : S_LAUNCH;
        else if (tmo_hit) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Command latch and run counter; both hold after DONE until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      reps_q  <= '0;
      runs_q  <= '0;
    end else if (accept) begin
      count_q <= cmd_count;
      reps_q  <= cmd_reps;
      runs_q  <= '0;
    end else if (finish_hit) begin
      runs_q  <= runs_inc;
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed testbench for loop_sequencer.
module tb_loop_sequencer;

`ifdef LOOP_SEQ_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_count = 8'd0;
  logic [3:0] cmd_reps = 4'd0;
  logic       eng_start;
  logic [7:0] eng_count;
  logic       eng_finish = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] runs_done;
  logic       timeout;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int dones = 0;

  loop_sequencer #(.CNT_W(8), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_reps(cmd_reps),
    .eng_start(eng_start), .eng_count(eng_count), .eng_finish(eng_finish),
    .busy(busy), .done(done), .runs_done(runs_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (eng_start) starts <= starts + 1;
    if (done)      dones  <= dones + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for exactly one edge (sequencer must be idle).
  task automatic issue(input logic [7:0] cnt, input logic [3:0] reps);
    cmd_valid = 1'b1; cmd_count = cnt; cmd_reps = reps;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({cmd_ready, eng_start, eng_count, busy, done, runs_done, timeout} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b st=%b cnt=%0d busy=%b done=%b runs=%0d tmo=%b", cmd_ready, eng_start, eng_count, busy, done, runs_done, timeout);
    end
    tick(); rst = 1'b0; tick();
  endtask

  task automatic test_single_run();
    int s0;
    s0 = starts;
    issue(8'd5, 4'd1);
    checks++;
    if (eng_start !== 1'b1 || eng_count !== 8'd5 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_launch got st=%b cnt=%0d rdy=%b busy=%b want 1 5 0 1", eng_start, eng_count, cmd_ready, busy);
    end
    for (int i = 0; i < 5; i++) tick();
    eng_finish = 1'b1; tick(); eng_finish = 1'b0;
    checks++;
    if (done !== 1'b1 || runs_done !== 4'd1) begin
      failures++;
      $display("FAIL single_done got done=%b runs=%0d want 1 1", done, runs_done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || runs_done !== 4'd1 || eng_count !== 8'd5 || starts - s0 != 1) begin
      failures++;
      $display("FAIL single_after got done=%b busy=%b runs=%0d cnt=%0d starts=%0d want 0 0 1 5 1", done, busy, runs_done, eng_count, starts - s0);
    end
  endtask

  task automatic test_multi_run();
    int s0, d0;
    s0 = starts; d0 = dones;
    issue(8'd7, 4'd3);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) tick();
      eng_finish = 1'b1; tick(); eng_finish = 1'b0;
      checks++;
      if (r < 2) begin
        if (eng_start !== 1'b1 || done !== 1'b0 || runs_done !== 4'(r + 1)) begin
          failures++;
          $display("FAIL multi_relaunch%0d got st=%b done=%b runs=%0d want 1 0 %0d", r, eng_start, done, runs_done, r + 1);
        end
      end else if (done !== 1'b1 || eng_start !== 1'b0 || runs_done !== 4'd3) begin
        failures++;
        $display("FAIL multi_done got done=%b st=%b runs=%0d want 1 0 3", done, eng_start, runs_done);
      end
    end
    tick();
    checks++;
    if (starts - s0 != 3 || dones - d0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL multi_totals got starts=%0d dones=%0d busy=%b want 3 1 0", starts - s0, dones - d0, busy);
    end
  endtask

  task automatic test_zero_reps();
    int s0;
    s0 = starts;
    issue(8'd0, 4'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || eng_start !== 1'b0 || runs_done !== 4'd0 || eng_count !== 8'd0) begin
      failures++;
      $display("FAIL zero_reps got done=%b busy=%b st=%b runs=%0d cnt=%0d want 1 1 0 0 0", done, busy, eng_start, runs_done, eng_count);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || starts != s0) begin
      failures++;
      $display("FAIL zero_reps_after got busy=%b done=%b starts=%0d want 0 0 0", busy, done, starts - s0);
    end
  endtask

  task automatic test_reset_midrun();
    int d0;
    d0 = dones;
    issue(8'd4, 4'd3);
    tick();
    eng_finish = 1'b1; tick(); eng_finish = 1'b0;
    tick();  // now in WAIT of run 2
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, eng_start, eng_count, busy, done, runs_done} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL midrun_reset got rdy=%b st=%b cnt=%0d busy=%b done=%b runs=%0d", cmd_ready, eng_start, eng_count, busy, done, runs_done);
    end
    tick(); tick();
    rst = 1'b0;
    eng_finish = 1'b1; tick(); eng_finish = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || runs_done !== 4'd0 || dones != d0) begin
      failures++;
      $display("FAIL midrun_stale got busy=%b runs=%0d dones=%0d want 0 0 0", busy, runs_done, dones - d0);
    end
    issue(8'd3, 4'd1);
    tick();
    eng_finish = 1'b1; tick(); eng_finish = 1'b0;
    checks++;
    if (done !== 1'b1 || runs_done !== 4'd1 || eng_count !== 8'd3) begin
      failures++;
      $display("FAIL midrun_recover got done=%b runs=%0d cnt=%0d want 1 1 3", done, runs_done, eng_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    eng_finish = 1'b1;
    issue(8'd2, 4'd2);  // finish high in IDLE is ignored
    cmd_valid = 1'b1; cmd_count = 8'd9; cmd_reps = 4'd1;
    tick();  // LAUNCH edge: finish ignored
    checks++;
    if (runs_done !== 4'd0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL stale_finish got runs=%0d busy=%b rdy=%b want 0 1 0", runs_done, busy, cmd_ready);
    end
    tick();
    checks++;
    if (runs_done !== 4'd1 || eng_start !== 1'b1 || eng_count !== 8'd2) begin
      failures++;
      $display("FAIL busy_cmd_ignored got runs=%0d st=%b cnt=%0d want 1 1 2", runs_done, eng_start, eng_count);
    end
    tick(); tick();
    eng_finish = 1'b0;
    checks++;
    if (done !== 1'b1 || runs_done !== 4'd2) begin
      failures++;
      $display("FAIL b2b_first_done got done=%b runs=%0d want 1 2", done, runs_done);
    end
    tick();  // IDLE: pending command accepted at the next edge
    checks++;
    if (cmd_ready !== 1'b1 || eng_count !== 8'd2) begin
      failures++;
      $display("FAIL b2b_idle got rdy=%b cnt=%0d want 1 2", cmd_ready, eng_count);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (eng_start !== 1'b1 || eng_count !== 8'd9 || runs_done !== 4'd0) begin
      failures++;
      $display("FAIL b2b_accept got st=%b cnt=%0d runs=%0d want 1 9 0", eng_start, eng_count, runs_done);
    end
    tick();
    eng_finish = 1'b1; tick(); eng_finish = 1'b0;
    tick();
  endtask

  task automatic test_max_reps();
    int s0;
    s0 = starts;
    issue(8'd1, 4'd15);
    eng_finish = 1'b1;
    for (int i = 0; i < 40 && done !== 1'b1; i++) tick();
    eng_finish = 1'b0;
    checks++;
    if (done !== 1'b1 || runs_done !== 4'd15 || starts - s0 != 15) begin
      failures++;
      $display("FAIL max_reps got done=%b runs=%0d starts=%0d want 1 15 15", done, runs_done, starts - s0);
    end
    tick(); tick();
    checks++;
    if (runs_done !== 4'd15 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL max_reps_hold got runs=%0d busy=%b tmo=%b want 15 0 0", runs_done, busy, timeout);
    end
  endtask

`ifdef LOOP_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    issue(8'd6, 4'd1);
    for (int k = 0; k < TMO; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL tmo_wait%0d got done=%b busy=%b want 0 1", k, done, busy);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || runs_done !== 4'd0) begin
      failures++;
      $display("FAIL tmo_abort got done=%b tmo=%b runs=%0d want 1 1 0", done, timeout, runs_done);
    end
    tick();
    issue(8'd6, 4'd1);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got tmo=%b want 0", timeout);
    end
    tick();
    eng_finish = 1'b1; tick(); eng_finish = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_single_run();
    test_multi_run();
    test_zero_reps();
    test_reset_midrun();
    test_back_to_back();
    test_max_reps();
`ifdef LOOP_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 Parameter CNT_W, default 8, width of the per-run iteration count.
REQ-002 Parameter TMO_CYC, default 255, cycles allowed in WAIT before a timeout abort (used only with LOOP_SEQ_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_count  input  CNT_W  iterations per engine run.
REQ-008 cmd_reps  input  4  number of engine runs requested.
REQ-009 eng_start  output  1  one-cycle pulse launching one loop-engine run.
REQ-010 eng_count  output  CNT_W  iteration count presented to the engine.
REQ-011 eng_finish  input  1  engine completion; one high sample ends the current run.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at command completion.
REQ-014 runs_done  output  4  runs completed for the current or last command.
REQ-015 timeout  output  1  sticky abort flag.

Function
REQ-016 FSM states: IDLE, LAUNCH, WAIT, DONE; 2-bit encoding.
REQ-017 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, latch cmd_count/cmd_reps, clear runs_done, go LAUNCH (cmd_reps!=0) or DONE (cmd_reps==0, engine never started).
REQ-018 cmd_ready SHALL be 0 in LAUNCH, WAIT and DONE; commands offered then are not consumed.
REQ-019 LAUNCH: eng_start=1 for exactly one cycle; next state WAIT unconditionally.
REQ-020 Latency: command accepted at edge N -> eng_start high during cycle N+1.
REQ-021 eng_count SHALL equal the latched count from acceptance until the next acceptance; a value of 0 is passed through unmodified.
REQ-022 eng_finish SHALL be ignored in IDLE, LAUNCH and DONE (stale completions discarded).
REQ-023 WAIT: on eng_finish=1, runs_done increments; if new runs_done==latched reps go DONE, else go LAUNCH (next eng_start one cycle after the finish sample).
REQ-024 runs_done SHALL saturate at 15 and hold its value after DONE until the next acceptance.
REQ-025 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-026 Back-to-back: a command valid in the IDLE cycle immediately after DONE SHALL be accepted in that cycle.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, cmd_ready=1, eng_start=0, eng_count=0, busy=0, done=0, runs_done=0, timeout=0, internal counters=0.
REQ-028 Reset asserted mid-run SHALL abandon the command without a done pulse; the first eng_finish after release is ignored unless a new command has launched.

Configuration
REQ-029 Macro LOOP_SEQ_TIMEOUT_EN defined: a WAIT-state counter runs from 0; reaching TMO_CYC without eng_finish sets timeout=1 and goes DONE (done pulses, runs_done not incremented); counter clears on entry to WAIT; timeout clears on next command acceptance.
REQ-030 Macro undefined: no watchdog logic; WAIT holds indefinitely; timeout tied 0.

Verification
REQ-031 After reset, cmd_count=5, cmd_reps=1, eng_finish 6 cycles after eng_start -> one eng_start, eng_count=5, done pulse next cycle, runs_done=1.
REQ-032 cmd_reps=3, engine finishing 4 cycles after each start -> exactly 3 eng_start pulses, each one cycle after the previous finish, runs_done=3, single done.
REQ-033 cmd_reps=0 -> no eng_start, done pulse in cycle N+1, runs_done=0, busy high one cycle.
REQ-034 rst asserted during WAIT of run 2 of 3 -> all outputs at reset values same cycle, no done; new command afterwards runs normally.
REQ-035 eng_finish held high through IDLE and LAUNCH -> ignored until WAIT; cmd_valid during busy -> not accepted until IDLE.
REQ-036 With LOOP_SEQ_TIMEOUT_EN, TMO_CYC=10, eng_finish never asserted -> timeout=1 and done pulse at the 10th WAIT cycle, runs_done=0; next accepted command clears timeout.
